// File: rtl/bus_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and the framing FSM state type.
package bus_uart_pkg;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIV    = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 4;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

endpackage

// File: rtl/bus_uart_tx_if.sv
// CPU memory-bus responder port. A write is a single-cycle strobe sampled on the
// rising edge; reads have no strobe and return data one cycle after the address.
interface bus_uart_tx_if;
   logic [31:0] memAddress;
   logic [31:0] memWriteData;
   logic        memWrite;
   logic [3:0]  byteMask;
   logic [31:0] memReadData;
   logic        sel;

   modport master (output memAddress, memWriteData, memWrite, byteMask,
                   input  memReadData, sel);
   modport slave  (input  memAddress, memWriteData, memWrite, byteMask,
                   output memReadData, sel);
endinterface

// File: rtl/bus_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count. Pushes while full and pops while empty
// are ignored; full is judged on the pre-edge occupancy.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic             doPush;
   logic             doPop;

   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign doPush = push && !full;
   assign doPop  = pop && !empty;
   assign dout   = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= din;
   end

   // Depth is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + AW'(1);
         if (doPop)  rdPtr <= rdPtr + AW'(1);
         case ({doPush, doPop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register window on the CPU bus, TX FIFO,
// and a framing FSM driving the registered tx line.
module bus_uart_tx
   import bus_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
   parameter int          CLKS_PER_BIT = 52,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic          clk,
   input  logic          reset,
   bus_uart_tx_if.slave  bus,
   output logic          tx,
   output tx_state_t     dbgState
);
   localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0]    DIV_RESET = 16'(CLKS_PER_BIT);

   logic          hit;
   logic [1:0]    offset;
   logic          wrEn;
   logic          pushReq;
   logic          popReq;
   logic [7:0]    fifoData;
   logic          fifoFull;
   logic          fifoEmpty;
   logic [CW-1:0] fifoCount;
   logic          overflow;
   logic [15:0]   divReg;
   logic [31:0]   statusWord;
   logic [31:0]   readMux;
   logic          unusedBits;

   tx_state_t     state, nextState;
   logic [15:0]   cnt, cntNext;
   logic [7:0]    shiftReg, shiftNext;
   logic [2:0]    bitIdx, bitNext;
   logic          txNext;
   logic [15:0]   reloadVal;
   logic          cntZero;

   assign hit        = (bus.memAddress[31:4] == BASE_ADDR[31:4]);
   assign bus.sel    = hit;
   assign offset     = bus.memAddress[3:2];
   assign wrEn       = bus.memWrite && hit;
   assign pushReq    = wrEn && (offset == OFF_TXDATA) && bus.byteMask[0];
   assign unusedBits = ^{bus.memAddress[1:0], bus.memWriteData[31:16]};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) txFifo (
      .clk   (clk),
      .reset (reset),
      .push  (pushReq),
      .pop   (popReq),
      .din   (bus.memWriteData[7:0]),
      .dout  (fifoData),
      .full  (fifoFull),
      .empty (fifoEmpty),
      .count (fifoCount)
   );

   // ---------------- register file ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
         divReg   <= DIV_RESET;
      end else begin
         if (pushReq && fifoFull)
            overflow <= 1'b1;
         else if (wrEn && (offset == OFF_STATUS) && bus.byteMask[0] && bus.memWriteData[ST_OVF])
            overflow <= 1'b0;
         if (wrEn && (offset == OFF_DIV)) begin
            if (bus.byteMask[0]) divReg[7:0]  <= bus.memWriteData[7:0];
            if (bus.byteMask[1]) divReg[15:8] <= bus.memWriteData[15:8];
         end
      end
   end

   always_comb begin
      statusWord                     = '0;
      statusWord[ST_BUSY]            = (state != IDLE);
      statusWord[ST_FULL]            = fifoFull;
      statusWord[ST_EMPTY]           = fifoEmpty;
      statusWord[ST_OVF]             = overflow;
      statusWord[ST_CNT_LSB +: 4]    = 4'(fifoCount);
   end

   always_comb begin
      readMux = '0;
      case (offset)
         OFF_STATUS: readMux = statusWord;
         OFF_DIV:    readMux = {16'h0000, divReg};
         default:    readMux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) bus.memReadData <= '0;
      else        bus.memReadData <= hit ? readMux : '0;
   end

   // ---------------- framing FSM ----------------
   // DIV is sampled only at counter reloads, so a mid-frame write never cuts a bit short.
   assign reloadVal = (divReg == 16'd0) ? 16'd0 : (divReg - 16'd1);
   assign cntZero   = (cnt == 16'd0);
   assign dbgState  = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         shiftReg <= '0;
         bitIdx   <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= nextState;
         cnt      <= cntNext;
         shiftReg <= shiftNext;
         bitIdx   <= bitNext;
         tx       <= txNext;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (!fifoEmpty)                  nextState = START;
         START:   if (cntZero)                     nextState = DATA;
         DATA:    if (cntZero && bitIdx == 3'd7)   nextState = STOP;
         STOP:    if (cntZero)                     nextState = IDLE;
         default:                                  nextState = IDLE;
      endcase
   end

   always_comb begin
      popReq    = 1'b0;
      cntNext   = cnt;
      shiftNext = shiftReg;
      bitNext   = bitIdx;
      txNext    = tx;
      case (state)
         IDLE: begin
            txNext = 1'b1;
            if (!fifoEmpty) begin
               popReq    = 1'b1;
               shiftNext = fifoData;
               txNext    = 1'b0;
               cntNext   = reloadVal;
            end
         end
         START: begin
            if (cntZero) begin
               cntNext   = reloadVal;
               txNext    = shiftReg[0];
               shiftNext = {1'b0, shiftReg[7:1]};
               bitNext   = 3'd0;
            end else begin
               cntNext   = cnt - 16'd1;
            end
         end
         DATA: begin
            if (cntZero) begin
               cntNext = reloadVal;
               if (bitIdx == 3'd7) begin
                  txNext = 1'b1;
               end else begin
                  txNext    = shiftReg[0];
                  shiftNext = {1'b0, shiftReg[7:1]};
                  bitNext   = bitIdx + 3'd1;
               end
            end else begin
               cntNext = cnt - 16'd1;
            end
         end
         STOP: begin
            txNext = 1'b1;
            if (!cntZero) cntNext = cnt - 16'd1;
         end
         default: txNext = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: directed register sequences with random
// payloads, checked against a line-level frame model and a UART receiver model.
module tb_bus_uart_tx;
   import bus_uart_pkg::*;

   localparam logic [31:0] BASE = 32'h0001_0000;

   logic      clk = 1'b0;
   logic      reset = 1'b0;
   logic      tx;
   tx_state_t dbgState;

   bus_uart_tx_if bus();

   bus_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(52), .FIFO_DEPTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .tx       (tx),
      .dbgState (dbgState)
   );

   always #5 clk = ~clk;

   int testsRun = 0;
   int testsFailed = 0;

   logic       txHist[$];
   logic       busyHist[$];
   logic       expQ[$];
   logic [7:0] sentQ[$];
   logic [7:0] rxQ[$];

   // Line history: one sample per cycle, taken 1ns after each rising edge.
   always @(posedge clk) begin
      #1;
      txHist.push_back(tx);
      busyHist.push_back(dbgState != IDLE);
   end

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
      bus.memAddress   = addr;
      bus.memWriteData = data;
      bus.byteMask     = mask;
      bus.memWrite     = 1'b1;
      @(negedge clk);
      bus.memWrite     = 1'b0;
      bus.byteMask     = 4'b0000;
   endtask

   task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
      bus.memAddress = addr;
      bus.memWrite   = 1'b0;
      @(negedge clk);
      data = bus.memReadData;
   endtask

   // Expected 8N1 frame: start, 8 data bits LSB first, stop; per-bit durations.
   task automatic appendFrame(input logic [7:0] b, input int firstLen, input int restLen);
      for (int i = 0; i < firstLen; i++) expQ.push_back(1'b0);
      for (int j = 0; j < 8; j++)
         for (int i = 0; i < restLen; i++) expQ.push_back(b[j]);
      for (int i = 0; i < restLen; i++) expQ.push_back(1'b1);
   endtask

   task automatic compareLine(input string tag, input int base);
      int   mism = 0;
      int   first = -1;
      logic obsFirst = 1'b0;
      logic expFirst = 1'b0;
      for (int i = 0; i < expQ.size() + 50 && txHist.size() < base + expQ.size(); i++)
         @(negedge clk);
      for (int k = 0; k < expQ.size(); k++) begin
         if (base + k >= txHist.size() || txHist[base + k] !== expQ[k]) begin
            mism++;
            if (first < 0) begin
               first    = k;
               expFirst = expQ[k];
               obsFirst = (base + k < txHist.size()) ? txHist[base + k] : 1'bx;
            end
         end
      end
      testsRun++;
      assert (mism == 0) else begin
         testsFailed++;
         $error("FAIL %s: %0d of %0d samples wrong, first at %0d observed %b expected %b",
                tag, mism, expQ.size(), first, obsFirst, expFirst);
      end
   endtask

   task automatic waitIdle(input string tag, input int budget);
      logic [31:0] s;
      int          ok = 0;
      for (int i = 0; i < budget && ok == 0; i++) begin
         busRead(BASE + 32'h4, s);
         if (s === 32'h4) ok = 1;
      end
      check({tag, " idle reached"}, ok, 1);
   endtask

   // Receiver model: find falling edges in the history and sample mid-bit.
   task automatic decodeLine(input int from, input int div);
      int i = from;
      while (i + 10 * div <= txHist.size()) begin
         if (txHist[i] === 1'b0 && (i == 0 || txHist[i - 1] === 1'b1)) begin
            logic [7:0] b;
            for (int j = 0; j < 8; j++) b[j] = txHist[i + div / 2 + (j + 1) * div];
            rxQ.push_back(b);
            i += 10 * div;
         end else begin
            i++;
         end
      end
   endtask

   logic [31:0] r;
   logic [7:0]  d, a, b, c;
   int          base, rxStart, rel, dv, e, nb, zeros;

   initial begin
      bus.memAddress   = 32'h0;
      bus.memWriteData = 32'h0;
      bus.memWrite     = 1'b0;
      bus.byteMask     = 4'b0000;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset tx", tx, 1'b1);
      check("reset memReadData", bus.memReadData, 32'h0);
      check("reset fsm", dbgState, IDLE);
      reset = 1'b1;
      busRead(BASE + 32'h4, r); check("status after reset", r, 32'h4);
      busRead(BASE + 32'h8, r); check("div after reset", r, 32'd52);
      busRead(BASE + 32'h0, r); check("txdata reads zero", r, 32'h0);

      // Single frames at several divisors, including DIV=0 (treated as 1)
      for (int f = 0; f < 4; f++) begin
         case (f)
            0:       begin dv = 4; d = 8'hA5; end
            1:       begin dv = $urandom_range(1, 6); d = 8'($urandom); end
            2:       begin dv = 0; d = 8'($urandom); end
            default: begin dv = $urandom_range(2, 5); d = 8'($urandom); end
         endcase
         e = (dv == 0) ? 1 : dv;
         busWrite(BASE + 32'h8, 32'(dv), 4'b0011);
         busWrite(BASE, {24'h0, d}, 4'b0001);
         base = txHist.size();
         expQ.delete();
         appendFrame(d, e, e);
         expQ.push_back(1'b1);
         compareLine($sformatf("frame%0d div%0d byte%02h line", f, dv, d), base);
         nb = 0;
         for (int k = 0; k < 10 * e; k++) nb += int'(busyHist[base + k]);
         check($sformatf("frame%0d busy cycles", f), nb, 10 * e);
         check($sformatf("frame%0d idle after stop", f), busyHist[base + 10 * e], 1'b0);
      end

      // Fill FIFO while the first byte is already on the line, then overflow
      busWrite(BASE + 32'h8, 32'd52, 4'b0011);
      rxStart = txHist.size();
      sentQ.delete();
      for (int i = 0; i < 9; i++) begin
         d = 8'($urandom);
         sentQ.push_back(d);
         busWrite(BASE, {24'h0, d}, 4'b0001);
      end
      busRead(BASE + 32'h4, r); check("status full count8", r, 32'h83);
      busWrite(BASE, 32'($urandom_range(0, 255)), 4'b0001);
      busRead(BASE + 32'h4, r); check("status overflow", r, 32'h8B);
      busWrite(BASE + 32'h4, 32'h8, 4'b0001);
      busRead(BASE + 32'h4, r); check("status overflow cleared", r, 32'h83);
      waitIdle("fifo drain", 8000);
      rxQ.delete();
      decodeLine(rxStart, 52);
      check("rx byte count", rxQ.size(), 9);
      for (int i = 0; i < rxQ.size() && i < 9; i++)
         check($sformatf("rx byte %0d", i), rxQ[i], sentQ[i]);

      // Masks, DIV lanes, reserved offset, out-of-window accesses
      busWrite(BASE, 32'hFF, 4'b1110);
      busRead(BASE + 32'h4, r); check("masked push ignored", r, 32'h4);
      busWrite(BASE + 32'h8, 32'hFFFF_FFFF, 4'b1111);
      busRead(BASE + 32'h8, r); check("div upper reads zero", r, 32'h0000_FFFF);
      busWrite(BASE + 32'h8, 32'h1234_5604, 4'b0001);
      busRead(BASE + 32'h8, r); check("div lane0 only", r, 32'h0000_FF04);
      busWrite(BASE + 32'h8, 32'h0, 4'b0010);
      busRead(BASE + 32'h9, r); check("div lane1, low addr bits ignored", r, 32'h0000_0004);
      busWrite(BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111);
      busRead(BASE + 32'hC, r); check("reserved reads zero", r, 32'h0);
      busRead(BASE + 32'h8, r); check("reserved write ignored", r, 32'h4);
      busWrite(BASE + 32'h10, 32'h55, 4'b0001);
      busRead(BASE + 32'h4, r); check("out-of-window write ignored", r, 32'h4);
      busRead(BASE + 32'h8, r);
      #1 check("sel in window", bus.sel, 1'b1);
      bus.memAddress = BASE + 32'h18;
      #1 check("sel out of window", bus.sel, 1'b0);
      @(negedge clk);
      check("out-of-window read zero", bus.memReadData, 32'h0);

      // DIV change mid start-bit, three queued frames
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      busWrite(BASE, {24'h0, a}, 4'b0001);
      base = txHist.size();
      busWrite(BASE, {24'h0, b}, 4'b0001);
      busWrite(BASE + 32'h8, 32'd8, 4'b0011);
      busWrite(BASE, {24'h0, c}, 4'b0001);
      expQ.delete();
      appendFrame(a, 4, 8); expQ.push_back(1'b1);
      appendFrame(b, 8, 8); expQ.push_back(1'b1);
      appendFrame(c, 8, 8); expQ.push_back(1'b1);
      compareLine("div change mid-frame line", base);

      // Async reset during data bit 3
      busWrite(BASE + 32'h8, 32'd4, 4'b0011);
      d = 8'($urandom) & 8'hF7;
      busWrite(BASE, {24'h0, d}, 4'b0001);
      base = txHist.size();
      busWrite(BASE, 32'($urandom_range(0, 255)), 4'b0001);
      for (int i = 0; i < 100 && txHist.size() < base + 18; i++) @(negedge clk);
      check("tx low in data bit 3", tx, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("async reset tx", tx, 1'b1);
      check("async reset memReadData", bus.memReadData, 32'h0);
      check("async reset fsm", dbgState, IDLE);
      @(negedge clk);
      reset = 1'b1;
      rel = txHist.size();
      busRead(BASE + 32'h4, r); check("status after mid-frame reset", r, 32'h4);
      busRead(BASE + 32'h8, r); check("div after mid-frame reset", r, 32'd52);
      repeat (30) @(negedge clk);
      zeros = 0;
      for (int k = rel; k < txHist.size(); k++) if (txHist[k] !== 1'b1) zeros++;
      check("tx idle after reset release", zeros, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule

// File: doc/bus_uart_tx.md
Name: bus_uart_tx

Overview:
Memory-mapped UART transmitter that acts as a responder on the CPU memory bus (memAddress/memWriteData/memWrite/byteMask/memReadData), alongside RAM. The CPU writes bytes into a small TX FIFO and polls status. A framing FSM serialises the bytes as 8N1 on a single tx pin. The SoC muxes memReadData between RAM and this block using the sel output.

Parameters:
BASE_ADDR, 32'h0001_0000, 16-byte-aligned base of the register window
CLKS_PER_BIT, 52, reset value of DIV (6 MHz / 115200)
FIFO_DEPTH, 8, TX FIFO entries, power of two, >=2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
memAddress  input  32  bus byte address from CPU
memWriteData  input  32  bus write data
memWrite  input  1  write strobe, sampled on the rising clk edge
byteMask  input  4  write byte enables, bit i = lane [8i+7:8i]
memReadData  output  32  registered read data
sel  output  1  combinational: memAddress lies in this block's window
tx  output  1  serial line, idle high

Behaviour:
- Decode: hit = (memAddress[31:4] == BASE_ADDR[31:4]); sel = hit; offset = memAddress[3:2]; memAddress[1:0] ignored.
- Registers:
  - 0x0 TXDATA (W). A write with byteMask[0]=1 pushes memWriteData[7:0]. Reads return 0.
  - 0x4 STATUS (R). bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count (zero-extended), others 0. Writing 1 to bit3 with byteMask[0]=1 clears overflow.
  - 0x8 DIV (RW). [15:0] clocks per bit; lanes 0/1 written per byteMask; [31:16] read 0.
  - 0xC reserved. Reads 0, writes ignored.
- Read latency is 1 cycle: each edge, memReadData <= hit ? reg(offset) : 0. Reads have no side effects.
- Writes take effect on the edge where memWrite=1 and hit=1. A write with byteMask=0 does nothing.
- Push while full: the byte is dropped and overflow is set. Full is evaluated before any same-cycle pop, so a pop in the same cycle does not rescue the push.
- Push while empty: the FIFO holds the entry after the edge. The FSM pops it on the next edge.
- FSM states IDLE, START, DATA, STOP. A baud counter loads effective DIV - 1, where DIV=0 is treated as 1.
  - IDLE: tx=1. If FIFO non-empty: pop into shift register, tx=0, load counter, go to START.
  - START/DATA: when counter hits 0, reload it and drive the next bit LSB first. After the START bit comes data bit 0; after data bit 7 comes STOP (tx=1).
  - STOP: when counter hits 0, go to IDLE.
  - Each bit lasts exactly DIV cycles.
  - Back-to-back frames: IDLE lasts 1 cycle between frames, so the frame period is 10*DIV+1.
- A DIV write mid-frame takes effect at the next counter reload, never mid-bit.
- tx is registered and glitch-free.
- Reset (async, any time including mid-frame):
  - tx=1, memReadData=0, FIFO emptied, overflow=0.
  - DIV=CLKS_PER_BIT, FSM=IDLE, counter=0.
- Write-to-line latency: TXDATA written at edge N with an empty FIFO and idle FSM gives tx falling after edge N+1.

Decomposition:
- Package bus_uart_pkg holds:
  - register offset constants
  - STATUS bit-position constants
  - enum tx_state_t {IDLE, START, DATA, STOP}
- One sub-module, sync_fifo: parameterised width/depth, push/pop/full/empty/count, async active-low reset. It is instantiated with width 8.

Test Plan:
1. Reset -> tx=1, memReadData=0. Read 0x4 -> 32'h0000_0004 (empty). Read 0x8 -> 52.
2. Write DIV=4, then TXDATA=0xA5 -> tx low 1 cycle after the write edge. Bits 1,0,1,0,0,1,0,1 follow, each 4 cycles, then stop-high 4 cycles. Total 40 cycles; busy=1 throughout.
3. Nine TXDATA writes in consecutive cycles with DIV=52 and the FSM idle -> the first byte pops immediately, so all nine are accepted and STATUS shows full=1, count=8, overflow=0. A tenth write -> overflow=1, count stays 8. Write 0x8 to STATUS -> overflow=0.
4. TXDATA write with byteMask=4'b1110 -> no push, count 0. Read of any offset with memAddress outside the window -> sel=0, memReadData=0 next cycle.
5. Write DIV=8 while the current bit (DIV=4) is in progress -> the current bit stays 4 cycles, subsequent bits last 8. Two queued bytes -> frame starts spaced 10*DIV+1.
6. Assert reset during data bit 3 -> tx=1 immediately (async), FIFO empty, DIV=52. After release with no writes, tx stays 1.
